// File: rtl/subunit_pkg.sv
// Shared constants and round-robin helper for the subunit dispatcher.
package subunit_pkg;
  localparam int N_CHILD_DEF = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W       = 16;
  localparam int IDX_W       = 4;

  // First set bit of mask at or after start, wrapping modulo n (n <= 16).
  function automatic logic [IDX_W-1:0] rr_next(input logic [15:0]      mask,
                                               input logic [IDX_W-1:0] start,
                                               input int               n);
    logic [IDX_W-1:0] res;
    logic             found;
    int               idx;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = int'(start) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && mask[idx[3:0]]) begin
        res   = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/subunit_dispatch_fifo.sv
// Two-entry synchronous FIFO with occupancy count; head is always visible.
module subunit_dispatch_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count
);
  logic [DATA_W-1:0] r_mem [2];
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_count;

  // Caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/subunit_dispatcher.sv
// Round-robin dispatcher from one parent stream to N_CHILD enabled children.
// Define SUBUNIT_DISPATCH_STATS_EN to add saturating per-child dispatch counters (disp_cnt).
module subunit_dispatcher
  import subunit_pkg::*;
#(
  parameter int N_CHILD = N_CHILD_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [N_CHILD-1:0]         child_en,
  output logic [N_CHILD-1:0]         out_valid,
  input  logic [N_CHILD-1:0]         out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy
`ifdef SUBUNIT_DISPATCH_STATS_EN
  ,
  output logic [N_CHILD*CNT_W-1:0]   disp_cnt
`endif
);
  logic [1:0]       w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_ne;
  logic             w_tgt_rdy;
  logic             w_any;
  logic [15:0]      w_mask;
  logic [IDX_W-1:0] w_tgt_inc;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_tgt;
  logic             r_tgt_vld;

  subunit_dispatch_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_head  (out_data),
    .o_count (w_count)
  );

  assign in_ready = (w_count != 2'd2);
  assign w_ne     = (w_count != 2'd0);
  assign busy     = w_ne;
  assign w_push   = in_valid & in_ready;

  always_comb begin
    out_valid = '0;
    w_tgt_rdy = 1'b0;
    for (int i = 0; i < N_CHILD; i++) begin
      if (r_tgt == 4'(i)) begin
        out_valid[i] = w_ne & r_tgt_vld;
        w_tgt_rdy    = out_ready[i];
      end
    end
  end

  assign w_pop     = w_ne & r_tgt_vld & w_tgt_rdy;
  assign w_tgt_inc = (r_tgt == 4'(N_CHILD - 1)) ? '0 : r_tgt + 4'd1;
  assign w_ptr_nxt = w_pop ? w_tgt_inc : r_ptr;
  assign w_mask    = 16'(child_en);
  assign w_any     = |child_en;
  assign w_sel     = rr_next(w_mask, w_ptr_nxt, N_CHILD);

  // Target stays locked while a word is presented; it re-selects when idle,
  // after a handshake, or while waiting for a non-zero mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_tgt     <= '0;
      r_tgt_vld <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (!w_ne || w_pop || !r_tgt_vld) begin
        r_tgt     <= w_sel;
        r_tgt_vld <= w_any;
      end
    end
  end

`ifdef SUBUNIT_DISPATCH_STATS_EN
  logic [CNT_W-1:0] r_cnt [N_CHILD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CHILD; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHILD; i++) begin
        if (w_pop && (r_tgt == 4'(i)) && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < N_CHILD; i++) disp_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif
endmodule

// File: doc/subunit_dispatcher.md
# subunit_dispatcher

Round-robin stream dispatcher between a parent stage and its five child sub-units. Accepts one word per cycle from the parent over a valid/ready handshake. Buffers up to two words and hands each word to exactly one enabled child in strict rotating order. Sits directly upstream of the child instances and is their only data source.

## Interface
Parameters:
- `N_CHILD`, 5, number of child outputs (2..16).
- `DATA_W`, 32, payload width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  parent word valid.
- `in_ready`  out  1  dispatcher can accept.
- `in_data`  in  DATA_W  parent payload.
- `child_en`  in  N_CHILD  per-child enable mask; disabled children are skipped.
- `out_valid`  out  N_CHILD  one-hot (or zero) valid toward children.
- `out_ready`  in  N_CHILD  per-child ready.
- `out_data`  out  DATA_W  shared payload bus, meaningful where `out_valid` set.
- `busy`  out  1  buffer non-empty.
- `disp_cnt`  out  N_CHILD*16  per-child dispatch counts; present only with `SUBUNIT_DISPATCH_STATS_EN`.

## Operation
- 2-entry FIFO. `in_ready` = FIFO count < 2, driven from registered count. Input handshake when `in_valid & in_ready`.
- State:
  - `ptr`: next-candidate index.
  - `tgt`: locked target.
  - `tgt_vld`: target locked flag.
- Target select: the first index i at or after `ptr`, modulo N_CHILD, with `child_en[i]=1`.
- FIFO empty: each cycle, `tgt`/`tgt_vld` reload from target select. `tgt_vld=0` if the mask is all zero.
- FIFO non-empty: `out_valid[tgt] = tgt_vld`. All other bits are 0. `out_data` = FIFO head.
- While presenting, `tgt` and `out_data` hold stable until `out_ready[tgt]`, regardless of `child_en` changes.
- Output handshake:
  - pop head;
  - `ptr` ← (tgt+1) mod N_CHILD;
  - re-lock `tgt` from target select using the new `ptr` and current mask, in the same edge.
- Mask all zero with FIFO non-empty and `tgt_vld=0`: no output, hold. Lock occurs in the first cycle the mask is non-zero.
- Push and pop in the same cycle with count=2: not possible, because `in_ready=0`. With count=1, count stays 1.
- `out_ready` of non-target children is ignored.

## Timing
- Reset values:
  - FIFO empty;
  - `in_ready=1`;
  - `out_valid=0`;
  - `out_data=0`;
  - `busy=0`;
  - `ptr=0`;
  - `tgt_vld=0`;
  - `disp_cnt=0`.
- Latency: word accepted at edge t is presented (`out_valid` high) in cycle t+1, provided the mask is non-zero.
- Throughput: 1 word/cycle with children continuously ready.
- Reset asserted mid-transfer: immediate clear. The buffered words are dropped and `ptr` returns to 0.
- `out_data` and `out_valid` are registered/FIFO-driven. There is no combinational path from `out_ready` to `out_valid`.

## Configuration
- `SUBUNIT_DISPATCH_STATS_EN`
  - Defined: adds `disp_cnt` with one 16-bit counter per child. A counter increments on each output handshake to its child and saturates at 0xFFFF.
  - Undefined: the counters and the port are absent, and the remaining behaviour is identical.

## Structure
- Shared package `subunit_pkg`:
  - `N_CHILD_DEF=5`;
  - `DATA_W_DEF=32`;
  - `CNT_W=16`;
  - the `rr_next()` helper function that returns the first set mask bit at or after an index.
- One sub-module: `subunit_dispatch_fifo`, a 2-entry synchronous FIFO with count output.
- Selection logic and counters live in the top.

## Test plan
- Reset, all children enabled and ready, push 0xA0..0xA6 back-to-back:
  - children 0,1,2,3,4,0,1 receive them in order;
  - one word per cycle;
  - first `out_valid[0]` one cycle after the first accept.
- `child_en=5'b10101`, push 4 words: delivered to children 0,2,4,0.
- Target child 1 holds `out_ready=0` for 5 cycles:
  - `out_valid[1]` and `out_data` stay stable;
  - FIFO fills and `in_ready` drops after 2 accepts;
  - on ready, transfer resumes to 2.
- Clear `child_en[1]` while child 1 is presenting: that word still goes to 1, and the next goes to 2.
- `child_en=0`, push 2 words: no `out_valid` and `in_ready=0`. Enable child 3: words go to 3 and then 3 again.
- With `SUBUNIT_DISPATCH_STATS_EN`: 12 words to all-enabled children gives `disp_cnt` = {2,2,2,3,3}, listed for children 4..0. Assert `rst_n` low mid-stream: all counts and outputs return to 0.
